// File: rtl/sm_arith_pkg.sv
// Shared mode encodings and the sign-magnitude packing helper for the add/sub datapath.
// sm_pack places the sign at bit w and forces a zero magnitude to be positive.
package sm_arith_pkg;

   localparam logic MODE_UNS = 1'b0;
   localparam logic MODE_SM  = 1'b1;

   // Wide enough for any practical W; callers cast to W+1 bits.
   localparam int SM_MAXW = 64;

   function automatic logic [SM_MAXW:0] sm_pack(input logic sign,
                                                 input logic [SM_MAXW-1:0] mag,
                                                 input int w);
      logic [SM_MAXW:0] r;
      r = {1'b0, mag};
      if (sign && (mag != '0))
         r = r | ((SM_MAXW+1)'(1) << w);
      return r;
   endfunction

endpackage

// File: rtl/sm_addsub_core.sv
// Combinational W-bit unsigned / sign-magnitude add-subtract.
// Expects the effective sign of b and the magnitude compare to be precomputed upstream.
module sm_addsub_core import sm_arith_pkg::*; #(
   parameter int W = 8
) (
   input  logic         i_sa,
   input  logic         i_sub,
   input  logic         i_sgn_a,
   input  logic         i_sgn_b,
   input  logic         i_a_ge_b,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic [W:0]   o_data,
   output logic         o_c
);

   logic [W:0]   w_uns;
   logic [W-1:0] w_mag;
   logic         w_sgn;
   logic [W-2:0] w_ma;
   logic [W-2:0] w_mb;

   assign w_ma = i_a[W-2:0];
   assign w_mb = i_b[W-2:0];

   always_comb begin
      w_mag  = '0;
      w_sgn  = 1'b0;
      o_data = '0;
      o_c    = 1'b0;
      // The top bit of the (W+1)-bit difference is exactly the borrow.
      w_uns  = i_sub ? ({1'b0, i_a} - {1'b0, i_b}) : ({1'b0, i_a} + {1'b0, i_b});
      if (i_sgn_a == i_sgn_b) begin
         w_mag = {1'b0, w_ma} + {1'b0, w_mb};
         w_sgn = i_sgn_a;
      end else if (i_a_ge_b) begin
         w_mag = {1'b0, w_ma - w_mb};
         w_sgn = i_sgn_a;
      end else begin
         w_mag = {1'b0, w_mb - w_ma};
         w_sgn = i_sgn_b;
      end
      if (i_sa == MODE_SM) begin
         o_data = (W+1)'(sm_pack(w_sgn, SM_MAXW'(w_mag), W));
         o_c    = w_mag[W-1];
      end else begin
         o_data = w_uns;
         o_c    = w_uns[W];
      end
   end

endmodule

// File: rtl/sm_addsub_pipe.sv
// Two-stage valid/ready adder/subtractor (unsigned or sign-magnitude) with accumulator feedback.
// Latency 2, throughput 1/cycle; stalls accumulate inputs until the pipeline drains.
module sm_addsub_pipe import sm_arith_pkg::*; #(
   parameter int W = 8
) (
   input  logic         iClk,
   input  logic         iRst,
   input  logic         iValid,
   output logic         oReady,
   input  logic         iSA,
   input  logic         iSub,
   input  logic         iAcc,
   input  logic         iClr,
   input  logic [W-1:0] iData_a,
   input  logic [W-1:0] iData_b,
   output logic         oValid,
   input  logic         iReady,
   output logic [W:0]   oData,
   output logic         oData_C
);

   logic         r_s1_vld;
   logic         r_s1_sa;
   logic         r_s1_sub;
   logic         r_s1_sgn_a;
   logic         r_s1_sgn_b;
   logic         r_s1_a_ge_b;
   logic [W-1:0] r_s1_a;
   logic [W-1:0] r_s1_b;
   logic         r_s2_vld;
   logic         r_s2_c;
   logic [W:0]   r_s2_dat;
   logic [W:0]   r_acc;

   logic         w_sm;
   logic [W-1:0] w_a;
   logic         w_a_ge_b;
   logic         w_out_xfer;
   logic         w_s2_free;
   logic         w_s1_adv;
   logic         w_hazard;
   logic         w_in_xfer;
   logic [W:0]   w_core_dat;
   logic         w_core_c;

   assign w_sm = (iSA != MODE_UNS);

   // In SM mode the accumulator's magnitude-carry bit is dropped when fed back.
   always_comb begin
      w_a = iData_a;
      if (iAcc)
         w_a = w_sm ? {r_acc[W], r_acc[W-2:0]} : r_acc[W-1:0];
   end

   assign w_a_ge_b   = (w_a[W-2:0] >= iData_b[W-2:0]);
   assign w_out_xfer = r_s2_vld & iReady;
   assign w_s2_free  = ~r_s2_vld | iReady;
   assign w_s1_adv   = r_s1_vld & w_s2_free;
   assign w_hazard   = iValid & iAcc & (r_s1_vld | r_s2_vld);
   assign oReady     = ~iRst & ~w_hazard & (~r_s1_vld | w_s1_adv);
   assign w_in_xfer  = iValid & oReady;

   sm_addsub_core #(.W(W)) u_core (
      .i_sa     (r_s1_sa),
      .i_sub    (r_s1_sub),
      .i_sgn_a  (r_s1_sgn_a),
      .i_sgn_b  (r_s1_sgn_b),
      .i_a_ge_b (r_s1_a_ge_b),
      .i_a      (r_s1_a),
      .i_b      (r_s1_b),
      .o_data   (w_core_dat),
      .o_c      (w_core_c)
   );

   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_s1_vld    <= 1'b0;
         r_s1_sa     <= 1'b0;
         r_s1_sub    <= 1'b0;
         r_s1_sgn_a  <= 1'b0;
         r_s1_sgn_b  <= 1'b0;
         r_s1_a_ge_b <= 1'b0;
         r_s1_a      <= '0;
         r_s1_b      <= '0;
         r_s2_vld    <= 1'b0;
         r_s2_c      <= 1'b0;
         r_s2_dat    <= '0;
         r_acc       <= '0;
      end else begin
         if (~r_s1_vld | w_s1_adv)
            r_s1_vld <= w_in_xfer;
         if (w_in_xfer) begin
            r_s1_sa     <= iSA;
            r_s1_sub    <= iSub;
            r_s1_sgn_a  <= w_a[W-1];
            r_s1_sgn_b  <= iData_b[W-1] ^ iSub;
            r_s1_a_ge_b <= w_a_ge_b;
            r_s1_a      <= w_a;
            r_s1_b      <= iData_b;
         end
         // S2 data only changes when it is free, so a held result stays stable.
         if (w_s2_free) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
               r_s2_dat <= w_core_dat;
               r_s2_c   <= w_core_c;
            end
         end
         if (iClr)
            r_acc <= '0;
         else if (w_out_xfer)
            r_acc <= r_s2_dat;
      end
   end

   assign oValid  = r_s2_vld;
   assign oData   = r_s2_dat;
   assign oData_C = r_s2_c;

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Directed-vector bench for sm_addsub_pipe (W=8) with hand-computed expectations.
module tb_sm_addsub_pipe;

   logic       iClk = 1'b0;
   logic       iRst;
   logic       iValid;
   logic       oReady;
   logic       iSA;
   logic       iSub;
   logic       iAcc;
   logic       iClr;
   logic [7:0] iData_a;
   logic [7:0] iData_b;
   logic       oValid;
   logic       iReady;
   logic [8:0] oData;
   logic       oData_C;

   int total = 0;
   int bad   = 0;

   sm_addsub_pipe #(.W(8)) dut (
      .iClk    (iClk),
      .iRst    (iRst),
      .iValid  (iValid),
      .oReady  (oReady),
      .iSA     (iSA),
      .iSub    (iSub),
      .iAcc    (iAcc),
      .iClr    (iClr),
      .iData_a (iData_a),
      .iData_b (iData_b),
      .oValid  (oValid),
      .iReady  (iReady),
      .oData   (oData),
      .oData_C (oData_C)
   );

   always #5 iClk = ~iClk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Entered and left at a falling edge; drops iValid after the accepting edge.
   task automatic send(input logic sa, input logic sub, input logic acc,
                       input logic [7:0] a, input logic [7:0] b);
      int n = 0;
      iSA = sa; iSub = sub; iAcc = acc; iData_a = a; iData_b = b; iValid = 1'b1;
      #1;
      while (!oReady && n < 20) begin
         @(negedge iClk); #1; n++;
      end
      chk("send_ready", {15'd0, oReady}, 16'd1);
      @(negedge iClk);
      iValid = 1'b0; iAcc = 1'b0;
   endtask

   task automatic get_result(input string tag, input logic [8:0] dat, input logic c,
                             input logic clr);
      int n = 0;
      iReady = 1'b1;
      #1;
      while (!oValid && n < 20) begin
         @(negedge iClk); #1; n++;
      end
      chk({tag, "_vld"}, {15'd0, oValid}, 16'd1);
      chk({tag, "_dat"}, {7'd0, oData}, {7'd0, dat});
      chk({tag, "_c"},   {15'd0, oData_C}, {15'd0, c});
      iClr = clr;
      @(negedge iClk);
      iClr = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      iRst = 1'b1; iValid = 1'b0; iSA = 1'b0; iSub = 1'b0; iAcc = 1'b0; iClr = 1'b0;
      iData_a = 8'd0; iData_b = 8'd0; iReady = 1'b1;

      // Reset state
      repeat (2) @(negedge iClk);
      #1;
      chk("rst_valid", {15'd0, oValid}, 16'd0);
      chk("rst_data",  {7'd0, oData}, 16'd0);
      chk("rst_c",     {15'd0, oData_C}, 16'd0);
      chk("rst_ready", {15'd0, oReady}, 16'd0);
      @(negedge iClk);
      iRst = 1'b0;
      #1;
      chk("idle_ready", {15'd0, oReady}, 16'd1);
      @(negedge iClk);

      // Unsigned add with exact latency
      send(1'b0, 1'b0, 1'b0, 8'd200, 8'd100);
      #1;
      chk("lat_early", {15'd0, oValid}, 16'd0);
      @(negedge iClk); #1;
      chk("lat_vld", {15'd0, oValid}, 16'd1);
      chk("add_dat", {7'd0, oData}, 16'h012C);
      chk("add_c",   {15'd0, oData_C}, 16'd1);
      @(negedge iClk);

      // Unsigned subtract
      send(1'b0, 1'b1, 1'b0, 8'd3, 8'd5);
      get_result("sub_neg", 9'h1FE, 1'b1, 1'b0);
      send(1'b0, 1'b1, 1'b0, 8'd5, 8'd3);
      get_result("sub_pos", 9'h002, 1'b0, 1'b0);

      // Sign-magnitude
      send(1'b1, 1'b0, 1'b0, 8'h85, 8'h03);
      get_result("sm_mix", 9'h102, 1'b0, 1'b0);
      send(1'b1, 1'b0, 1'b0, 8'h83, 8'h03);
      get_result("sm_zero", 9'h000, 1'b0, 1'b0);
      send(1'b1, 1'b0, 1'b0, 8'hC0, 8'hC0);
      get_result("sm_ovf", 9'h180, 1'b1, 1'b0);
      send(1'b1, 1'b0, 1'b0, 8'h80, 8'h80);
      get_result("sm_negz", 9'h000, 1'b0, 1'b0);

      // Backpressure: four back-to-back inputs, iReady low
      iReady = 1'b0;
      iSA = 1'b0; iSub = 1'b0; iAcc = 1'b0; iData_a = 8'd1; iData_b = 8'd2; iValid = 1'b1;
      #1;
      chk("bp_rdy0", {15'd0, oReady}, 16'd1);
      @(negedge iClk);
      iData_a = 8'd250; iData_b = 8'd10;
      #1;
      chk("bp_rdy1", {15'd0, oReady}, 16'd1);
      chk("bp_vld1", {15'd0, oValid}, 16'd0);
      @(negedge iClk);
      iSA = 1'b1; iSub = 1'b1; iData_a = 8'h05; iData_b = 8'h07;
      #1;
      chk("bp_full", {15'd0, oReady}, 16'd0);
      chk("bp_vld2", {15'd0, oValid}, 16'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge iClk); #1;
         chk("bp_hold_rdy", {15'd0, oReady}, 16'd0);
         chk("bp_hold_dat", {7'd0, oData}, 16'h0003);
      end
      @(negedge iClk);
      iReady = 1'b1;
      #1;
      chk("bp_resume_rdy", {15'd0, oReady}, 16'd1);
      chk("bp_out0", {7'd0, oData}, 16'h0003);
      @(negedge iClk);
      iSA = 1'b0; iSub = 1'b1; iData_a = 8'd5; iData_b = 8'd3;
      #1;
      chk("bp_rdy3", {15'd0, oReady}, 16'd1);
      chk("bp_out1", {7'd0, oData}, 16'h0104);
      chk("bp_out1_c", {15'd0, oData_C}, 16'd1);
      @(negedge iClk);
      iValid = 1'b0;
      #1;
      chk("bp_out2", {7'd0, oData}, 16'h0102);
      @(negedge iClk); #1;
      chk("bp_out3", {7'd0, oData}, 16'h0002);
      chk("bp_out3_vld", {15'd0, oValid}, 16'd1);
      @(negedge iClk); #1;
      chk("bp_drained", {15'd0, oValid}, 16'd0);
      @(negedge iClk);

      // Accumulate: clear, then ACC + 10 three times
      iClr = 1'b1;
      @(negedge iClk);
      iClr = 1'b0;
      iSA = 1'b0; iSub = 1'b0; iAcc = 1'b1; iData_a = 8'hFF; iData_b = 8'd10; iValid = 1'b1;
      #1;
      chk("acc_rdy0", {15'd0, oReady}, 16'd1);
      @(negedge iClk); #1;
      chk("acc_haz_s1", {15'd0, oReady}, 16'd0);
      @(negedge iClk); #1;
      chk("acc_haz_s2", {15'd0, oReady}, 16'd0);
      chk("acc_r1", {7'd0, oData}, 16'h000A);
      @(negedge iClk); #1;
      chk("acc_drained", {15'd0, oReady}, 16'd1);
      @(negedge iClk);
      iValid = 1'b0; iAcc = 1'b0;
      get_result("acc_r2", 9'h014, 1'b0, 1'b0);
      send(1'b0, 1'b0, 1'b1, 8'hFF, 8'd10);
      get_result("acc_r3", 9'h01E, 1'b0, 1'b0);
      // Clear coinciding with an output transfer must win
      send(1'b0, 1'b0, 1'b1, 8'h00, 8'd5);
      get_result("acc_r4", 9'h023, 1'b0, 1'b1);
      send(1'b0, 1'b0, 1'b1, 8'h00, 8'd1);
      get_result("acc_clr", 9'h001, 1'b0, 1'b0);

      // Reset with two transactions in flight
      iReady = 1'b0;
      send(1'b0, 1'b0, 1'b0, 8'd7, 8'd8);
      send(1'b0, 1'b0, 1'b0, 8'd9, 8'd9);
      iRst = 1'b1;
      @(negedge iClk); #1;
      chk("mrst_vld", {15'd0, oValid}, 16'd0);
      chk("mrst_rdy", {15'd0, oReady}, 16'd0);
      iRst = 1'b0; iReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge iClk); #1;
         chk("mrst_no_stale", {15'd0, oValid}, 16'd0);
      end
      @(negedge iClk);
      send(1'b0, 1'b0, 1'b1, 8'h00, 8'd0);
      get_result("mrst_acc", 9'h000, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
